// File: rtl/dtag_arb_pkg.sv
// Shared D$ tag/status definitions: status bit layout, fill status encodings
// and the invalidate-sweep state type.
package dtag_arb_pkg;

    localparam int unsigned STAT_W   = 5;
    localparam int unsigned STAT_V0  = 0;
    localparam int unsigned STAT_V1  = 1;
    localparam int unsigned STAT_D0  = 2;
    localparam int unsigned STAT_D1  = 3;
    localparam int unsigned STAT_LRU = 4;

    typedef logic [STAT_W-1:0] stat_t;

    typedef enum logic {
        FLS_IDLE,
        FLS_FLUSH
    } fls_state_e;

    // A fill touches only its own way's valid/dirty bits plus the shared LRU bit.
    function automatic stat_t fill_stat_we(input logic way);
        stat_t we;
        we = '0;
        we[STAT_LRU] = 1'b1;
        if (way) begin
            we[STAT_V1] = 1'b1;
            we[STAT_D1] = 1'b1;
        end else begin
            we[STAT_V0] = 1'b1;
            we[STAT_D0] = 1'b1;
        end
        return we;
    endfunction

    // Freshly filled way is valid and clean; LRU points at the other way.
    function automatic stat_t fill_stat_in(input logic way);
        stat_t sd;
        sd = '0;
        sd[STAT_LRU] = ~way;
        if (way) begin
            sd[STAT_V1] = 1'b1;
        end else begin
            sd[STAT_V0] = 1'b1;
        end
        return sd;
    endfunction

endpackage

// File: rtl/dtag_flush_seq.sv
// Invalidate-all sweep sequencer: walks every set index once per start pulse
// and flags completion in the first idle cycle afterwards.
module dtag_flush_seq
    import dtag_arb_pkg::*;
#(
    parameter int unsigned IDX_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [IDX_W-1:0] o_cnt
);

    fls_state_e       r_state;
    fls_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FLS_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            FLS_IDLE: begin
                if (i_start) begin
                    w_state_nxt = FLS_FLUSH;
                end
            end
            FLS_FLUSH: begin
                // Counter wraps to 0 on the last index, leaving it ready for the next sweep.
                w_cnt_nxt = r_cnt + IDX_W'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = FLS_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = FLS_IDLE;
            end
        endcase
    end

    always_comb begin
        o_busy = (r_state == FLS_FLUSH);
        o_done = r_done;
        o_cnt  = r_cnt;
    end

endmodule

// File: rtl/dtag_arb.sv
// D$ tag/status array controller: arbitrates lookups, fills, status updates
// and the invalidate sweep onto the shared tag and status ports.
module dtag_arb
    import dtag_arb_pkg::*;
#(
    parameter int unsigned TAG_W   = 20,
    parameter int unsigned IDX_W   = 9,
    parameter int unsigned AGE_LIM = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_req,
    input  logic [IDX_W-1:0]  lk_idx,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              lk_gnt,
    output logic              lk_rsp_vld,
    output logic [1:0]        lk_hit,
    input  logic              fl_req,
    input  logic [IDX_W-1:0]  fl_idx,
    input  logic              fl_set,
    input  logic [TAG_W-1:0]  fl_tag,
    output logic              fl_gnt,
    input  logic              st_req,
    input  logic [IDX_W-1:0]  st_idx,
    input  logic [STAT_W-1:0] st_we,
    input  logic [STAT_W-1:0] st_data,
    output logic              st_gnt,
    input  logic              fls_start,
    output logic              fls_busy,
    output logic              fls_done,
    output logic [IDX_W-1:0]  dt_addr,
    output logic [TAG_W-1:0]  dt_cmp_addr,
    output logic [TAG_W-1:0]  dt_tag_in,
    output logic              dt_set_sel,
    output logic              dt_tag_we,
    output logic [IDX_W-1:0]  dt_stat_addr,
    output logic [STAT_W-1:0] dt_stat_in,
    output logic [STAT_W-1:0] dt_stat_we,
    input  logic [1:0]        dt_hit
);

    localparam int unsigned AGE_W = (AGE_LIM < 1) ? 1 : $clog2(AGE_LIM + 1);

    logic [AGE_W-1:0] r_age;
    logic             r_lk_vld;
    logic             w_busy;
    logic [IDX_W-1:0] w_cnt;
    logic             w_age_hit;
    logic             w_fl_gnt;
    logic             w_lk_gnt;
    logic             w_st_gnt;

    dtag_flush_seq #(.IDX_W(IDX_W)) u_flush_seq (
        .clk     (clk),
        .reset   (reset),
        .i_start (fls_start),
        .o_busy  (w_busy),
        .o_done  (fls_done),
        .o_cnt   (w_cnt)
    );

    // A status request starved for AGE_LIM cycles takes the status port from a fill.
    always_comb begin
        w_age_hit = st_req && (r_age == AGE_W'(AGE_LIM));
        w_fl_gnt  = !w_busy && fl_req && !w_age_hit;
        w_lk_gnt  = !w_busy && lk_req && !w_fl_gnt;
        w_st_gnt  = !w_busy && st_req && !w_fl_gnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_age    <= '0;
            r_lk_vld <= 1'b0;
        end else begin
            r_lk_vld <= w_lk_gnt;
            if (!st_req || w_st_gnt) begin
                r_age <= '0;
            end else if (!w_busy && (r_age != AGE_W'(AGE_LIM))) begin
                r_age <= r_age + AGE_W'(1);
            end
        end
    end

    always_comb begin
        dt_addr      = '0;
        dt_cmp_addr  = '0;
        dt_tag_in    = '0;
        dt_set_sel   = 1'b0;
        dt_tag_we    = 1'b0;
        dt_stat_addr = '0;
        dt_stat_in   = '0;
        dt_stat_we   = '0;
        if (w_busy) begin
            dt_stat_addr = w_cnt;
            dt_stat_we   = '1;
        end else if (w_fl_gnt) begin
            dt_addr      = fl_idx;
            dt_tag_in    = fl_tag;
            dt_set_sel   = fl_set;
            dt_tag_we    = 1'b1;
            dt_stat_addr = fl_idx;
            dt_stat_we   = fill_stat_we(fl_set);
            dt_stat_in   = fill_stat_in(fl_set);
        end else begin
            if (w_lk_gnt) begin
                dt_addr     = lk_idx;
                dt_cmp_addr = lk_tag;
            end
            if (w_st_gnt) begin
                dt_stat_addr = st_idx;
                dt_stat_we   = st_we;
                dt_stat_in   = st_data;
            end
        end
    end

    always_comb begin
        lk_gnt     = w_lk_gnt;
        fl_gnt     = w_fl_gnt;
        st_gnt     = w_st_gnt;
        fls_busy   = w_busy;
        lk_rsp_vld = r_lk_vld;
        lk_hit     = r_lk_vld ? dt_hit : 2'b00;
    end

endmodule

// File: tb/tb_dtag_arb.sv
// Directed bench for dtag_arb with a behavioural arbitration model and a
// tag/status array model standing in for dtag_shell.
module tb_dtag_arb;

    localparam int unsigned TAG_W   = 20;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned AGE_LIM = 3;
    localparam int unsigned NSET    = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             lk_req, fl_req, fl_set, st_req, fls_start;
    logic [IDX_W-1:0] lk_idx, fl_idx, st_idx;
    logic [TAG_W-1:0] lk_tag, fl_tag;
    logic [4:0]       st_we, st_data;
    logic             lk_gnt, lk_rsp_vld, fl_gnt, st_gnt, fls_busy, fls_done;
    logic [1:0]       lk_hit;
    logic [IDX_W-1:0] dt_addr, dt_stat_addr;
    logic [TAG_W-1:0] dt_cmp_addr, dt_tag_in;
    logic             dt_set_sel, dt_tag_we;
    logic [4:0]       dt_stat_in, dt_stat_we;
    logic [1:0]       dt_hit = 2'b00;

    dtag_arb #(.TAG_W(TAG_W), .IDX_W(IDX_W), .AGE_LIM(AGE_LIM)) dut (
        .clk(clk), .reset(reset),
        .lk_req(lk_req), .lk_idx(lk_idx), .lk_tag(lk_tag), .lk_gnt(lk_gnt),
        .lk_rsp_vld(lk_rsp_vld), .lk_hit(lk_hit),
        .fl_req(fl_req), .fl_idx(fl_idx), .fl_set(fl_set), .fl_tag(fl_tag), .fl_gnt(fl_gnt),
        .st_req(st_req), .st_idx(st_idx), .st_we(st_we), .st_data(st_data), .st_gnt(st_gnt),
        .fls_start(fls_start), .fls_busy(fls_busy), .fls_done(fls_done),
        .dt_addr(dt_addr), .dt_cmp_addr(dt_cmp_addr), .dt_tag_in(dt_tag_in),
        .dt_set_sel(dt_set_sel), .dt_tag_we(dt_tag_we), .dt_stat_addr(dt_stat_addr),
        .dt_stat_in(dt_stat_in), .dt_stat_we(dt_stat_we), .dt_hit(dt_hit)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    bit               m_busy = 1'b0;
    int               m_cnt  = 0;
    bit               m_done = 1'b0;
    int               m_age  = 0;
    bit               m_rsp  = 1'b0;
    logic [1:0]       m_hit  = 2'b00;
    logic [1:0]       nx_hit = 2'b00;
    logic [TAG_W-1:0] a_tag0 [NSET] = '{default: '0};
    logic [TAG_W-1:0] a_tag1 [NSET] = '{default: '0};
    logic [4:0]       a_stat [NSET] = '{default: '0};

    always @(negedge clk) begin
        bit               age_hit, e_fl, e_lk, e_st, was_busy;
        logic [IDX_W-1:0] ex_addr, ex_saddr;
        logic [TAG_W-1:0] ex_cmp, ex_tin;
        logic             ex_sel, ex_twe;
        logic [4:0]       ex_sin, ex_swe;
        int               s;

        age_hit = st_req && (m_age == AGE_LIM);
        e_fl = !m_busy && fl_req && !age_hit;
        e_lk = !m_busy && lk_req && !e_fl;
        e_st = !m_busy && st_req && !e_fl;
        ex_addr = '0; ex_saddr = '0; ex_cmp = '0; ex_tin = '0;
        ex_sel = 1'b0; ex_twe = 1'b0; ex_sin = '0; ex_swe = '0;
        if (m_busy) begin
            ex_saddr = m_cnt[IDX_W-1:0];
            ex_swe   = 5'h1f;
        end else if (e_fl) begin
            s        = fl_set ? 1 : 0;
            ex_addr  = fl_idx;
            ex_tin   = fl_tag;
            ex_sel   = fl_set;
            ex_twe   = 1'b1;
            ex_saddr = fl_idx;
            ex_swe   = 5'(16 + (1 << s) + (4 << s));
            ex_sin   = 5'(((s == 0) ? 16 : 0) + (1 << s));
        end else begin
            if (e_lk) begin
                ex_addr = lk_idx;
                ex_cmp  = lk_tag;
            end
            if (e_st) begin
                ex_saddr = st_idx;
                ex_swe   = st_we;
                ex_sin   = st_data;
            end
        end

        if (chk_en) begin
            chk("m_lk_gnt",     32'(lk_gnt),       32'(e_lk));
            chk("m_fl_gnt",     32'(fl_gnt),       32'(e_fl));
            chk("m_st_gnt",     32'(st_gnt),       32'(e_st));
            chk("m_fls_busy",   32'(fls_busy),     32'(m_busy));
            chk("m_fls_done",   32'(fls_done),     32'(m_done));
            chk("m_lk_rsp_vld", 32'(lk_rsp_vld),   32'(m_rsp));
            chk("m_lk_hit",     32'(lk_hit),       32'(m_rsp ? m_hit : 2'b00));
            chk("m_dt_addr",    32'(dt_addr),      32'(ex_addr));
            chk("m_dt_cmp",     32'(dt_cmp_addr),  32'(ex_cmp));
            chk("m_dt_tag_in",  32'(dt_tag_in),    32'(ex_tin));
            chk("m_dt_set_sel", 32'(dt_set_sel),   32'(ex_sel));
            chk("m_dt_tag_we",  32'(dt_tag_we),    32'(ex_twe));
            chk("m_dt_saddr",   32'(dt_stat_addr), 32'(ex_saddr));
            chk("m_dt_stat_in", 32'(dt_stat_in),   32'(ex_sin));
            chk("m_dt_stat_we", 32'(dt_stat_we),   32'(ex_swe));
        end

        // Array: read compares against contents before this cycle's writes.
        nx_hit = {a_stat[dt_addr][1] && (a_tag1[dt_addr] == dt_cmp_addr),
                  a_stat[dt_addr][0] && (a_tag0[dt_addr] == dt_cmp_addr)};
        if (e_lk) begin
            m_hit = {a_stat[lk_idx][1] && (a_tag1[lk_idx] == lk_tag),
                     a_stat[lk_idx][0] && (a_tag0[lk_idx] == lk_tag)};
        end
        if (dt_tag_we === 1'b1) begin
            if (dt_set_sel) a_tag1[dt_addr] = dt_tag_in;
            else            a_tag0[dt_addr] = dt_tag_in;
        end
        for (int b = 0; b < 5; b++) begin
            if (dt_stat_we[b] === 1'b1) a_stat[dt_stat_addr][b] = dt_stat_in[b];
        end

        if (reset) begin
            m_busy = 1'b0; m_cnt = 0; m_done = 1'b0; m_age = 0; m_rsp = 1'b0;
        end else begin
            was_busy = m_busy;
            m_rsp  = e_lk;
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == NSET) begin
                    m_cnt  = 0;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (fls_start) begin
                m_busy = 1'b1;
            end
            if (!st_req || e_st) m_age = 0;
            else if (!was_busy && m_age < AGE_LIM) m_age++;
        end
    end

    always @(posedge clk) dt_hit <= nx_hit;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        #3;
    endtask

    task automatic idle_in();
        lk_req = 0; lk_idx = '0; lk_tag = '0;
        fl_req = 0; fl_idx = '0; fl_set = 0; fl_tag = '0;
        st_req = 0; st_idx = '0; st_we = '0; st_data = '0;
        fls_start = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        reset = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc(); samp();
        chk("rst_lk_gnt", 32'(lk_gnt), 0);
        chk("rst_rsp_vld", 32'(lk_rsp_vld), 0);
        chk("rst_busy", 32'(fls_busy), 0);
        chk("rst_done", 32'(fls_done), 0);
        chk("rst_stat_we", 32'(dt_stat_we), 0);
        cyc(); reset = 1'b0;

        // Fill way1 at idx 5, then look it up
        cyc(); fl_req = 1; fl_idx = 5; fl_set = 1; fl_tag = 20'h01234; samp();
        chk("t1_fl_gnt", 32'(fl_gnt), 1);
        chk("t1_fill_we", 32'(dt_stat_we), 32'h1a);
        chk("t1_fill_in", 32'(dt_stat_in), 32'h02);
        cyc(); fl_req = 0; lk_req = 1; lk_idx = 5; lk_tag = 20'h01234; samp();
        chk("t1_lk_gnt", 32'(lk_gnt), 1);
        chk("t1_dt_addr", 32'(dt_addr), 5);
        cyc(); lk_tag = 20'h01235; samp();
        chk("t1_rsp_vld", 32'(lk_rsp_vld), 1);
        chk("t1_hit", 32'(lk_hit), 32'b10);
        cyc(); lk_req = 0; samp();
        chk("t1_miss", 32'(lk_hit), 32'b00);
        cyc(); samp();
        chk("t1_rsp_idle", 32'(lk_rsp_vld), 0);

        // Fill beats lookup on the shared tag port
        cyc(); fl_req = 1; fl_idx = 3; fl_set = 0; fl_tag = 20'habcde;
        lk_req = 1; lk_idx = 3; lk_tag = 20'habcde; samp();
        chk("t2_fl_gnt", 32'(fl_gnt), 1);
        chk("t2_lk_gnt", 32'(lk_gnt), 0);
        chk("t2_fill_we", 32'(dt_stat_we), 32'b10101);
        chk("t2_fill_in", 32'(dt_stat_in), 32'b10001);
        cyc(); fl_req = 0; samp();
        chk("t2_lk_gnt2", 32'(lk_gnt), 1);
        cyc(); lk_req = 0; samp();
        chk("t2_hit0", 32'(lk_hit), 32'b01);
        cyc(); lk_req = 1; lk_idx = 5; lk_tag = 20'h01234;
        st_req = 1; st_idx = 5; st_we = 5'h10; st_data = 5'h10; samp();
        chk("t2_dual_lk", 32'(lk_gnt), 1);
        chk("t2_dual_st", 32'(st_gnt), 1);
        chk("t2_dual_saddr", 32'(dt_stat_addr), 5);
        cyc(); idle_in(); samp();
        chk("t2_dual_hit", 32'(lk_hit), 32'b10);

        // Starved status request ages past a held fill
        cyc(); st_req = 1; st_idx = 2; st_we = 5'h04; st_data = 5'h04;
        fl_req = 1; fl_idx = 7; fl_set = 1; fl_tag = 20'h00777;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            samp();
            chk("t3_st_gnt", 32'(st_gnt), (i == 3) ? 1 : 0);
            chk("t3_fl_gnt", 32'(fl_gnt), (i == 3) ? 0 : 1);
        end

        // Full sweep with requests and a second start ignored
        cyc(); idle_in(); fls_start = 1; samp();
        chk("t4_busy_pre", 32'(fls_busy), 0);
        cyc(); fls_start = 0; lk_req = 1; fl_req = 1; st_req = 1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) cyc();
            fls_start = (i == 5);
            samp();
            chk("t4_busy", 32'(fls_busy), 1);
            chk("t4_saddr", 32'(dt_stat_addr), 32'(i));
            chk("t4_we", 32'(dt_stat_we), 32'h1f);
            chk("t4_in", 32'(dt_stat_in), 0);
            chk("t4_gnts", 32'({lk_gnt, fl_gnt, st_gnt}), 0);
        end
        cyc(); idle_in(); samp();
        chk("t4_busy_end", 32'(fls_busy), 0);
        chk("t4_done", 32'(fls_done), 1);
        cyc(); samp();
        chk("t4_done_clr", 32'(fls_done), 0);

        // Reset mid-sweep; lookup granted just before the sweep still responds
        cyc(); fls_start = 1; lk_req = 1; lk_idx = 5; lk_tag = 20'h01234; samp();
        chk("t5_lk_gnt", 32'(lk_gnt), 1);
        cyc(); fls_start = 0; lk_req = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            if (i == 7) reset = 1'b1;
            samp();
            if (i == 0) chk("t5_rsp_vld", 32'(lk_rsp_vld), 1);
            chk("t5_saddr", 32'(dt_stat_addr), 32'(i));
        end
        cyc(); reset = 1'b0; samp();
        chk("t5_busy", 32'(fls_busy), 0);
        chk("t5_we", 32'(dt_stat_we), 0);
        chk("t5_done", 32'(fls_done), 0);
        cyc(); samp();
        chk("t5_done2", 32'(fls_done), 0);
        cyc(); fls_start = 1; samp();
        cyc(); fls_start = 0; samp();
        chk("t5_restart_busy", 32'(fls_busy), 1);
        chk("t5_restart_addr", 32'(dt_stat_addr), 0);
        for (int i = 0; i < 18; i++) cyc();
        samp();
        chk("t5_idle", 32'(fls_busy), 0);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
